// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: decodes UART command bytes into control pulses merged with buttons,
// owns the mode/format inversion state and answers every byte with an ACK/NAK on TX.
module uart_cmd_ctrl #(
    parameter bit         ACK_EN   = 1'b1,
    parameter logic [7:0] NAK_CHAR = 8'h3F
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       i_btn_clear,
    input  logic       i_btn_runstop,
    input  logic       i_btn_up,
    input  logic       i_btn_down,
    input  logic       i_sw_mode,
    input  logic       i_sw_fmt,
    output logic       o_clear,
    output logic       o_runstop,
    output logic       o_up,
    output logic       o_down,
    output logic       o_mode,
    output logic       o_fmt,
    output logic       o_overrun
);
    typedef enum logic [2:0] {IDLE, DECODE, ACK_WAIT, ACK_SEND, ACK_DONE} state_t;

    state_t     state_q, state_d;
    logic [7:0] cmd_q, cmd_d, tx_data_q, tx_data_d, folded;
    logic       first_q, first_d, mode_inv_q, mode_inv_d, fmt_inv_q, fmt_inv_d;
    logic       overrun_q, overrun_d;
    logic       clear_q, runstop_q, up_q, down_q;
    logic       dec, u_clear, u_runstop, u_up, u_down, u_mode, u_fmt, known;

    assign folded    = (rx_data >= 8'h61 && rx_data <= 8'h7A) ? rx_data - 8'h20 : rx_data;
    assign dec       = state_q == DECODE;
    assign u_clear   = dec && cmd_q == 8'h43;
    assign u_runstop = dec && cmd_q == 8'h52;
    assign u_up      = dec && cmd_q == 8'h55;
    assign u_down    = dec && cmd_q == 8'h44;
    assign u_mode    = dec && cmd_q == 8'h4D;
    assign u_fmt     = dec && cmd_q == 8'h46;
    assign known     = u_clear | u_runstop | u_up | u_down | u_mode | u_fmt;

    assign mode_inv_d = mode_inv_q ^ u_mode;
    assign fmt_inv_d  = fmt_inv_q ^ u_fmt;
    assign overrun_d  = overrun_q | (rx_done && state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        tx_data_d = tx_data_q;
        first_d   = first_q;
        case (state_q)
            IDLE: begin
                if (rx_done) begin
                    cmd_d   = folded;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                tx_data_d = known ? cmd_q : NAK_CHAR;
                state_d   = ACK_EN ? ACK_WAIT : IDLE;
            end
            ACK_WAIT: state_d = tx_busy ? ACK_WAIT : ACK_SEND;
            ACK_SEND: begin
                first_d = 1'b1;
                state_d = ACK_DONE;
            end
            ACK_DONE: begin
                // TX busy only rises a cycle after tx_start, so the first cycle here is blind
                first_d = 1'b0;
                state_d = (first_q || tx_busy) ? ACK_DONE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            tx_data_q  <= '0;
            first_q    <= 1'b0;
            mode_inv_q <= 1'b0;
            fmt_inv_q  <= 1'b0;
            overrun_q  <= 1'b0;
            clear_q    <= 1'b0;
            runstop_q  <= 1'b0;
            up_q       <= 1'b0;
            down_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            tx_data_q  <= tx_data_d;
            first_q    <= first_d;
            mode_inv_q <= mode_inv_d;
            fmt_inv_q  <= fmt_inv_d;
            overrun_q  <= overrun_d;
            clear_q    <= i_btn_clear | u_clear;
            runstop_q  <= i_btn_runstop | u_runstop;
            up_q       <= i_btn_up | u_up;
            down_q     <= i_btn_down | u_down;
        end
    end

    assign tx_start  = state_q == ACK_SEND;
    assign tx_data   = tx_data_q;
    assign o_clear   = clear_q;
    assign o_runstop = runstop_q;
    assign o_up      = up_q;
    assign o_down    = down_q;
    assign o_mode    = i_sw_mode ^ mode_inv_q;
    assign o_fmt     = i_sw_fmt ^ fmt_inv_q;
    assign o_overrun = overrun_q;
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: directed vectors for uart_cmd_ctrl with hand-computed expectations.
module tb_uart_cmd_ctrl;
    logic       clk = 1'b0, rst = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_done = 1'b0, tx_busy, tx_start;
    logic [7:0] tx_data;
    logic       btn_clear = 1'b0, btn_runstop = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
    logic       sw_mode = 1'b0, sw_fmt = 1'b0;
    logic       o_clear, o_runstop, o_up, o_down, o_mode, o_fmt, o_overrun;
    logic       man_busy = 1'b0, tx_model = 1'b0;
    int         mb_cnt = 0;

    uart_cmd_ctrl dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
        .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
        .i_btn_clear(btn_clear), .i_btn_runstop(btn_runstop),
        .i_btn_up(btn_up), .i_btn_down(btn_down),
        .i_sw_mode(sw_mode), .i_sw_fmt(sw_fmt),
        .o_clear(o_clear), .o_runstop(o_runstop), .o_up(o_up), .o_down(o_down),
        .o_mode(o_mode), .o_fmt(o_fmt), .o_overrun(o_overrun)
    );

    always #5 clk = ~clk;

    // Simple TX stand-in: busy rises the cycle after tx_start and lasts 4 cycles
    assign tx_busy = tx_model ? (mb_cnt != 0) : man_busy;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) mb_cnt <= tx_start ? 4 : (mb_cnt != 0 ? mb_cnt - 1 : 0);

    int n_clear = 0, n_run = 0, n_up = 0, n_down = 0, n_tx = 0;
    int t_clear = 0, t_run = 0, t_up = 0, t_down = 0, t_tx = 0;
    logic [7:0] tx_seen = '0;
    always @(negedge clk) begin
        if (o_clear)   begin n_clear++; t_clear = cyc; end
        if (o_runstop) begin n_run++;   t_run   = cyc; end
        if (o_up)      begin n_up++;    t_up    = cyc; end
        if (o_down)    begin n_down++;  t_down  = cyc; end
        if (tx_start)  begin n_tx++;    t_tx    = cyc; tx_seen = tx_data; end
    end

    int vectors = 0, miscompares = 0;
    int b_clear, b_run, b_up, b_down, b_tx, t0, tb0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        b_clear = n_clear; b_run = n_run; b_up = n_up; b_down = n_down; b_tx = n_tx;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rx(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        t0 = cyc;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    initial begin
        idle(2);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_pulses", {o_clear, o_runstop, o_up, o_down}, 0);
        check("rst_mode_fmt", {o_mode, o_fmt}, 0);
        check("rst_overrun", o_overrun, 0);
        @(negedge clk) rst = 1'b1;
        idle(2);

        snap();
        rx(8'h52);
        idle(6);
        check("R_count", n_run - b_run, 1);
        check("R_latency", t_run - t0, 2);
        check("R_tx_count", n_tx - b_tx, 1);
        check("R_tx_time", t_tx - t0, 3);
        check("R_tx_data", tx_seen, 8'h52);
        check("R_others", (n_clear - b_clear) + (n_up - b_up) + (n_down - b_down), 0);

        tx_model = 1'b1;
        snap();
        rx(8'h75);
        idle(14);
        check("u_up_count", n_up - b_up, 1);
        check("u_tx_data", tx_seen, 8'h55);
        snap();
        rx(8'h5A);
        idle(14);
        check("Z_no_pulse", (n_clear - b_clear) + (n_run - b_run) + (n_up - b_up) + (n_down - b_down), 0);
        check("Z_tx_count", n_tx - b_tx, 1);
        check("Z_tx_nak", tx_seen, 8'h3F);
        check("model_overrun", o_overrun, 0);
        tx_model = 1'b0;

        snap();
        @(negedge clk);
        btn_up = 1'b1;
        tb0 = cyc;
        @(negedge clk) btn_up = 1'b0;
        idle(2);
        check("btn_up_count", n_up - b_up, 1);
        check("btn_up_latency", t_up - tb0, 1);

        snap();
        @(negedge clk);
        rx_data = 8'h63;
        rx_done = 1'b1;
        t0 = cyc;
        @(negedge clk);
        rx_done = 1'b0;
        btn_clear = 1'b1;
        @(negedge clk) btn_clear = 1'b0;
        idle(6);
        check("merge_clear_count", n_clear - b_clear, 1);
        check("merge_clear_time", t_clear - t0, 2);
        check("merge_tx_data", tx_seen, 8'h43);

        sw_mode = 1'b1;
        idle(1);
        check("mode_sw", o_mode, 1);
        rx(8'h4D);
        idle(6);
        check("M1_mode", o_mode, 0);
        check("M1_tx_data", tx_seen, 8'h4D);
        rx(8'h6D);
        idle(6);
        check("m2_mode", o_mode, 1);
        snap();
        @(negedge clk) btn_up = 1'b1;
        @(negedge clk) btn_up = 1'b0;
        idle(2);
        check("btn_up_mode", o_mode, 1);
        check("btn_up_pulse", n_up - b_up, 1);
        rx(8'h66);
        idle(6);
        check("f_fmt", o_fmt, 1);

        man_busy = 1'b1;
        snap();
        rx(8'h44);
        idle(1);
        rx(8'h43);
        idle(92);
        check("busy_down", n_down - b_down, 1);
        check("busy_no_tx", n_tx - b_tx, 0);
        check("busy_overrun", o_overrun, 1);
        @(negedge clk);
        man_busy = 1'b0;
        tb0 = cyc;
        idle(10);
        check("busy_tx_count", n_tx - b_tx, 1);
        check("busy_tx_time", t_tx - tb0, 1);
        check("busy_tx_data", tx_seen, 8'h44);
        check("dropped_clear", n_clear - b_clear, 0);
        check("overrun_sticky", o_overrun, 1);

        man_busy = 1'b1;
        rx(8'h52);
        idle(3);
        snap();
        @(negedge clk);
        sw_mode = 1'b1;
        rst = 1'b0;
        #1;
        check("arst_tx_start", tx_start, 0);
        check("arst_overrun", o_overrun, 0);
        check("arst_mode", o_mode, 1);
        check("arst_fmt", o_fmt, 0);
        check("arst_tx_data", tx_data, 0);
        man_busy = 1'b0;
        idle(2);
        @(negedge clk) rst = 1'b1;
        idle(5);
        check("arst_ack_lost", n_tx - b_tx, 0);
        rx(8'h46);
        idle(7);
        check("F_fmt", o_fmt, 1);
        check("F_tx_count", n_tx - b_tx, 1);
        check("F_tx_data", tx_seen, 8'h46);
        check("F_overrun", o_overrun, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
